// File: rtl/ip_amba_apb4_slave_regfile.sv
// APB4 completer fronting a bank of RW registers plus read-only hardware status words.
// Supports byte strobes, fixed wait states, PSLVERR and per-register write pulses.
module ip_amba_apb4_slave_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_REGS    = 16,
    parameter int RO_REGS     = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                           ip_amba_apb4_slave_regfile_clock,
    input  logic                           ip_amba_apb4_slave_regfile_reset,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERR,
    input  logic [RO_REGS*DATA_WIDTH-1:0]  hw_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    output logic                           fsm_state
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_W);
    localparam int NUM_RW   = NUM_REGS - RO_REGS;
    localparam int RW_DEPTH = (NUM_RW > 0) ? NUM_RW : 1;
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;

    logic [DATA_WIDTH-1:0] rw_regs [RW_DEPTH];
    logic [DATA_WIDTH-1:0] cur_val [NUM_REGS];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      setup_idx;
    logic                  setup_err;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;

    assign fsm_state = (state == ST_ACCESS);

    // Decode from the live bus; only meaningful in IDLE during a setup phase.
    assign word_idx  = PADDR >> OFF_BITS;
    assign setup_idx = word_idx[IDX_W-1:0];

    always_comb begin
        setup_err = 1'b0;
        if (|(PADDR & OFF_MASK))
            setup_err = 1'b1;
        if (32'(word_idx) >= 32'(NUM_REGS))
            setup_err = 1'b1;
        if (PWRITE && (32'(word_idx) >= 32'(NUM_RW)))
            setup_err = 1'b1;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
        if (i < NUM_RW) begin : g_rw
            assign cur_val[i] = rw_regs[i];
        end else begin : g_ro
            assign cur_val[i] = hw_status[(i-NUM_RW)*DATA_WIDTH +: DATA_WIDTH];
        end
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = cur_val[i];
    end

    // With zero wait states PREADY rises on the setup edge, so the read index
    // comes straight from the bus; otherwise from the latched transfer.
    always_comb begin
        rd_idx = (state == ST_IDLE) ? setup_idx : idx_q;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i))
                rd_val = cur_val[i];
        end
    end

    always_ff @(posedge ip_amba_apb4_slave_regfile_clock) begin
        if (ip_amba_apb4_slave_regfile_reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            idx_q        <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            PREADY       <= 1'b0;
            PSLVERR      <= 1'b0;
            PRDATA       <= '0;
            reg_wr_pulse <= '0;
            for (int i = 0; i < RW_DEPTH; i++)
                rw_regs[i] <= '0;
        end else begin
            reg_wr_pulse <= '0;
            case (state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        idx_q    <= setup_idx;
                        write_q  <= PWRITE;
                        err_q    <= setup_err;
                        wdata_q  <= PWDATA;
                        strb_q   <= PSTRB;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= ST_ACCESS;
                        if (WAIT_STATES == 0) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= setup_err;
                            PRDATA  <= (!PWRITE && !setup_err) ? rd_val : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                        PREADY   <= 1'b0;
                        PSLVERR  <= 1'b0;
                        PRDATA   <= '0;
                    end else if (PREADY) begin
                        if (write_q && !err_q) begin
                            for (int i = 0; i < NUM_RW; i++) begin
                                if (idx_q == IDX_W'(i)) begin
                                    for (int b = 0; b < STRB_W; b++) begin
                                        if (strb_q[b])
                                            rw_regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                                    end
                                    reg_wr_pulse[i] <= 1'b1;
                                end
                            end
                        end
                        state   <= ST_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end else if (wait_cnt > 4'd1) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        // Last wait cycle: PREADY rises for the following cycle.
                        wait_cnt <= '0;
                        PREADY   <= 1'b1;
                        PSLVERR  <= err_q;
                        PRDATA   <= (!write_q && !err_q) ? rd_val : '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_amba_apb4_slave_regfile.sv
// Directed bench: one default instance (A) and one with three wait states (B)
// sharing the APB bus signals but selected by separate PSEL lines.
module tb_ip_amba_apb4_slave_regfile;

    logic         clk = 1'b0;
    logic         rst;
    logic         psel_a, psel_b, penable, pwrite;
    logic [11:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [63:0]  hw_a, hw_b;

    logic         rdy_a, rdy_b, err_a, err_b, fsm_a, fsm_b;
    logic [31:0]  rdata_a, rdata_b;
    logic [511:0] regs_a, regs_b;
    logic [15:0]  pulse_a, pulse_b;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    ip_amba_apb4_slave_regfile u_dut_a (
        .ip_amba_apb4_slave_regfile_clock (clk),
        .ip_amba_apb4_slave_regfile_reset (rst),
        .PSEL         (psel_a),
        .PENABLE      (penable),
        .PWRITE       (pwrite),
        .PADDR        (paddr),
        .PWDATA       (pwdata),
        .PSTRB        (pstrb),
        .PREADY       (rdy_a),
        .PRDATA       (rdata_a),
        .PSLVERR      (err_a),
        .hw_status    (hw_a),
        .reg_out      (regs_a),
        .reg_wr_pulse (pulse_a),
        .fsm_state    (fsm_a)
    );

    ip_amba_apb4_slave_regfile #(.WAIT_STATES(3)) u_dut_b (
        .ip_amba_apb4_slave_regfile_clock (clk),
        .ip_amba_apb4_slave_regfile_reset (rst),
        .PSEL         (psel_b),
        .PENABLE      (penable),
        .PWRITE       (pwrite),
        .PADDR        (paddr),
        .PWDATA       (pwdata),
        .PSTRB        (pstrb),
        .PREADY       (rdy_b),
        .PRDATA       (rdata_b),
        .PSLVERR      (err_b),
        .hw_status    (hw_b),
        .reg_out      (regs_b),
        .reg_wr_pulse (pulse_b),
        .fsm_state    (fsm_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Setup at the first negedge, wait cycles, then the PREADY cycle (checked).
    task automatic xfer(input bit which, input bit wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int ws,
                        input bit exp_err, input logic [31:0] exp_rdata, input string tag);
        @(negedge clk);
        psel_a  = !which;
        psel_b  = which;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        for (int i = 0; i < ws; i++) begin
            @(negedge clk);
            penable = 1'b1;
            check({tag, "_wait_ready"}, 64'(which ? rdy_b : rdy_a), 64'(0));
        end
        @(negedge clk);
        penable = 1'b1;
        check({tag, "_ready"},  64'(which ? rdy_b : rdy_a), 64'(1));
        check({tag, "_slverr"}, 64'(which ? err_b : err_a), 64'(exp_err));
        check({tag, "_rdata"},  64'(which ? rdata_b : rdata_a), 64'(exp_rdata));
    endtask

    task automatic idle();
        @(negedge clk);
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        hw_a = {32'h0000_1234, 32'h0000_A5A5};
        hw_b = 64'h0;

        repeat (2) @(negedge clk);
        check("rst_ready",  64'(rdy_a), 64'(0));
        check("rst_slverr", 64'(err_a), 64'(0));
        check("rst_rdata",  64'(rdata_a), 64'(0));
        check("rst_pulse",  64'(pulse_a), 64'(0));
        check("rst_rw_regs_zero", 64'(|regs_a[447:0]), 64'(0));
        check("rst_fsm",    64'(fsm_a), 64'(0));
        check("ro_view_14", 64'(regs_a[14*32 +: 32]), 64'h0000_A5A5);
        rst = 1'b0;

        // RW round trip
        xfer(1'b0, 1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, "wr_rt");
        idle();
        check("wr_rt_pulse",   64'(pulse_a), 64'h0004);
        check("wr_rt_reg2",    64'(regs_a[2*32 +: 32]), 64'hDEAD_BEEF);
        check("wr_rt_ready_1cyc", 64'(rdy_a), 64'(0));
        idle();
        check("wr_rt_pulse_once", 64'(pulse_a), 64'h0000);
        xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF, "rd_rt");
        idle();
        check("rd_rt_no_pulse", 64'(pulse_a), 64'h0000);
        check("rd_rt_rdata_clr", 64'(rdata_a), 64'(0));

        // Byte strobes, back to back
        xfer(1'b0, 1'b1, 12'h000, 32'h1122_3344, 4'hF, 0, 1'b0, 32'h0, "wr_full");
        xfer(1'b0, 1'b1, 12'h000, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, 32'h0, "wr_strb");
        idle();
        check("strb_reg0",  64'(regs_a[31:0]), 64'h11BB_33DD);
        check("strb_pulse", 64'(pulse_a), 64'h0001);

        // Errors
        xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'h0, 0, 1'b1, 32'h0, "rd_oob");
        idle();
        xfer(1'b0, 1'b1, 12'h002, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, 32'h0, "wr_unaligned");
        idle();
        check("unaligned_reg0",  64'(regs_a[31:0]), 64'h11BB_33DD);
        check("unaligned_pulse", 64'(pulse_a), 64'h0000);
        xfer(1'b0, 1'b1, 12'h03C, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, 32'h0, "wr_ro");
        idle();
        check("wr_ro_pulse", 64'(pulse_a), 64'h0000);
        check("wr_ro_view",  64'(regs_a[15*32 +: 32]), 64'h0000_1234);

        // RO read
        xfer(1'b0, 1'b0, 12'h038, 32'h0, 4'h0, 0, 1'b0, 32'h0000_A5A5, "rd_ro");
        idle();

        // Zero-strobe write: no data change but a pulse
        xfer(1'b0, 1'b1, 12'h008, 32'h1234_5678, 4'h0, 0, 1'b0, 32'h0, "wr_nostrb");
        idle();
        check("nostrb_pulse", 64'(pulse_a), 64'h0004);
        check("nostrb_reg2",  64'(regs_a[2*32 +: 32]), 64'hDEAD_BEEF);

        // Wait states, back-to-back write then read
        xfer(1'b1, 1'b1, 12'h004, 32'h55AA_55AA, 4'hF, 3, 1'b0, 32'h0, "ws_wr");
        xfer(1'b1, 1'b0, 12'h004, 32'h0, 4'h0, 3, 1'b0, 32'h55AA_55AA, "ws_rd");
        idle();
        check("ws_reg1",  64'(regs_b[1*32 +: 32]), 64'h55AA_55AA);
        check("ws_pulse", 64'(pulse_b), 64'h0000);

        // Abort during wait states on B
        @(negedge clk);
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h010; pwdata = 32'h9999_9999; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        check("abort_wait1", 64'(rdy_b), 64'(0));
        @(negedge clk);
        check("abort_wait2", 64'(rdy_b), 64'(0));
        @(negedge clk);
        check("abort_wait3", 64'(rdy_b), 64'(0));
        psel_b = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(rdy_b), 64'(0));
        check("abort_fsm",   64'(fsm_b), 64'(0));
        check("abort_reg4",  64'(regs_b[4*32 +: 32]), 64'(0));
        check("abort_pulse", 64'(pulse_b), 64'h0000);
        @(negedge clk);
        check("abort_ready_late", 64'(rdy_b), 64'(0));

        // Reset on the completion edge of a write on A
        @(negedge clk);
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h00C; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        check("rstmid_ready", 64'(rdy_a), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        psel_a = 1'b0; penable = 1'b0;
        check("rstmid_ready_clr", 64'(rdy_a), 64'(0));
        check("rstmid_slverr",    64'(err_a), 64'(0));
        check("rstmid_rdata",     64'(rdata_a), 64'(0));
        check("rstmid_pulse",     64'(pulse_a), 64'h0000);
        check("rstmid_regs_clr",  64'(|regs_a[447:0]), 64'(0));
        check("rstmid_fsm",       64'(fsm_a), 64'(0));
        check("rstmid_ro_view",   64'(regs_a[15*32 +: 32]), 64'h0000_1234);
        rst = 1'b0;

        xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'h0, 0, 1'b0, 32'h0, "rd_after_rst");
        idle();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
